line_fill_ctrl: RTL



---
 rtl/line_fill_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/line_fill_ctrl.sv
// Refill controller that fetches 64-beat lines from backing memory for the prog and data caches.
// Round-robin arbitration, one outstanding memory read, one line-write strobe per returned beat.
module line_fill_ctrl #(
   parameter int BEATS  = 64,
   parameter int REQ_AW = 20
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                is_req_f_prog,
   input  logic [REQ_AW-1:0]   req_addr_f_prog,
   input  logic                is_req_f_data,
   input  logic [REQ_AW-1:0]   req_addr_f_data,
   output logic                mem_rd_req,
   output logic [REQ_AW+5:0]   mem_rd_addr,
   input  logic                mem_rd_valid,
   input  logic [511:0]        mem_rd_data,
   output logic [511:0]        read_main_prog_data,
   output logic [7:0]          read_main_prog_addr,
   output logic                is_write_prog_line,
   output logic [511:0]        read_main_data_data,
   output logic [7:0]          read_main_data_addr,
   output logic                is_write_data_line,
   output logic                busy
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] FETCH = 1'b1;

   localparam logic [5:0] LAST_BEAT = 6'(BEATS - 1);

   // Source encoding: 0 = prog, 1 = data
   localparam logic SRC_PROG = 1'b0;
   localparam logic SRC_DATA = 1'b1;

   logic [0:0]        r_state;
   logic [5:0]        r_beat;
   logic [REQ_AW-1:0] r_addr;
   logic              r_src;
   logic              r_lastGrant;
   logic              r_doneProg;
   logic              r_doneData;

   logic w_eligProg;
   logic w_eligData;
   logic w_grantAny;
   logic w_grantData;
   logic w_beatDone;
   logic w_lastBeat;

   // A source whose line just filled stays ineligible until the cache drops its request
   assign w_eligProg  = is_req_f_prog & ~r_doneProg;
   assign w_eligData  = is_req_f_data & ~r_doneData;
   assign w_grantAny  = w_eligProg | w_eligData;
   assign w_grantData = w_eligData & (~w_eligProg | (r_lastGrant == SRC_PROG));
   assign w_beatDone  = (r_state == FETCH) & mem_rd_valid;
   assign w_lastBeat  = w_beatDone & (r_beat == LAST_BEAT);

   assign busy        = (r_state == FETCH);
   assign mem_rd_req  = (r_state == FETCH);
   assign mem_rd_addr = {r_addr, r_beat};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_beat      <= '0;
         r_addr      <= '0;
         r_src       <= SRC_PROG;
         r_lastGrant <= SRC_DATA;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grantAny) begin
                  r_src   <= w_grantData;
                  r_addr  <= w_grantData ? req_addr_f_data : req_addr_f_prog;
                  r_beat  <= '0;
                  r_state <= FETCH;
               end
            end
            FETCH: begin
               // Beat counter is 6 bits, so the increment after the last beat lands back on 0
               if (mem_rd_valid) begin
                  r_beat <= r_beat + 6'd1;
                  if (r_beat == LAST_BEAT) begin
                     r_state     <= IDLE;
                     r_lastGrant <= r_src;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // A low request wins over a completing fill so a dropped request never leaves a stale flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_doneProg <= 1'b0;
         r_doneData <= 1'b0;
      end else begin
         if (!is_req_f_prog) begin
            r_doneProg <= 1'b0;
         end else if (w_lastBeat && (r_src == SRC_PROG)) begin
            r_doneProg <= 1'b1;
         end
         if (!is_req_f_data) begin
            r_doneData <= 1'b0;
         end else if (w_lastBeat && (r_src == SRC_DATA)) begin
            r_doneData <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read_main_prog_data <= '0;
         read_main_prog_addr <= '0;
         is_write_prog_line  <= 1'b0;
         read_main_data_data <= '0;
         read_main_data_addr <= '0;
         is_write_data_line  <= 1'b0;
      end else begin
         is_write_prog_line <= 1'b0;
         is_write_data_line <= 1'b0;
         if (w_beatDone) begin
            if (r_src == SRC_DATA) begin
               read_main_data_data <= mem_rd_data;
               read_main_data_addr <= {r_addr[1:0], r_beat};
               is_write_data_line  <= 1'b1;
            end else begin
               read_main_prog_data <= mem_rd_data;
               read_main_prog_addr <= {r_addr[1:0], r_beat};
               is_write_prog_line  <= 1'b1;
            end
         end
      end
   end

endmodule
